pipe_addsub: RTL and testbench
==============================

PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter SEGMENTS, default 4, number of carry segments and pipeline stages; WIDTH % SEGMENTS SHALL be 0.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  operand beat offered.
REQ-006 o_ready  output  1  block accepts beat this cycle.
REQ-007 i_number_1  input  WIDTH  operand A.
REQ-008 i_number_2  input  WIDTH  operand B.
REQ-009 i_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 i_carry  input  1  carry-in for multiword add (ignored when i_sub=1).
REQ-011 o_valid  output  1  result beat presented.
REQ-012 i_ready  input  1  downstream accepts result.
REQ-013 result_o  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-014 carry_o  output  1  unsigned carry-out (for sub: 1 = no borrow).
REQ-015 overflow_o  output  1  signed two's-complement overflow.
REQ-016 zero_o  output  1  result_o == 0.

Function
REQ-017 Beat accepted when i_valid && o_ready; result delivered when o_valid && i_ready.
REQ-018 Effective operation: A + (i_sub ? ~B : B) + (i_sub ? 1 : i_carry).
REQ-019 Stage k (0..SEGMENTS-1) adds bits [k*W/S +: W/S] using carry from stage k-1 registered result; lower segments and remaining operand bits carried forward in pipeline registers.
REQ-020 Latency: accepted beat appears on o_valid exactly SEGMENTS cycles after acceptance when not stalled.
REQ-021 Throughput: one beat per cycle with i_ready held high.
REQ-022 Pipeline advances as a whole: advance = !o_valid || i_ready; o_ready = advance.
REQ-023 When advance=0 every stage register, including valid bits, holds its value; result_o and flags stable until handshake.
REQ-024 Bubbles propagate as invalid stages; no bubble collapsing.
REQ-025 overflow_o = (sign A == sign of effective B) && (sign result != sign A).
REQ-026 Flags computed only in final stage, registered with result_o.
REQ-027 SEGMENTS=1 SHALL degenerate to a single registered full-width adder with latency 1.
REQ-028 Results delivered strictly in acceptance order.

Reset
REQ-029 i_rst_n low clears all stage valid bits asynchronously; o_valid=0, result_o=0, carry_o=0, overflow_o=0, zero_o=0.
REQ-030 Reset mid-operation discards all in-flight beats; none emerge after release.
REQ-031 o_ready SHALL be 1 in the first cycle after reset release.
REQ-032 Data registers other than outputs need no reset.

Structure
REQ-033 Shared package holds OP_ADD=1'b0, OP_SUB=1'b1 and the function computing segment width WIDTH/SEGMENTS.
REQ-034 One sub-module addsub_segment (parameter SEG_W): combinational SEG_W-bit add with carry-in/carry-out and top-two-bit carries for overflow; instantiated SEGMENTS times via generate.
REQ-035 Elaboration SHALL fail (static assertion) when WIDTH % SEGMENTS != 0 or SEGMENTS < 1.

Verification
REQ-036 WIDTH=32,S=4: A=0xFFFFFFFF, B=1, add, carry=0 -> after 4 cycles result 0x00000000, carry_o=1, zero_o=1, overflow_o=0.
REQ-037 A=0x7FFFFFFF, B=1, add -> result 0x80000000, overflow_o=1, carry_o=0; A=5, B=7, sub -> 0xFFFFFFFE, carry_o=0, overflow_o=0.
REQ-038 Back-to-back 8 random beats, i_ready=1 -> 8 results on consecutive cycles, in order, matching reference model.
REQ-039 i_ready low for 3 cycles with pipe full -> o_ready=0, outputs stable, no beat lost or duplicated after release.
REQ-040 Assert i_rst_n low with 3 beats in flight -> o_valid=0 immediately, no stale results after release.
REQ-041 Multiword: low word 0xFFFFFFFF+1 carry_o=1 fed as i_carry to high word 0+0 -> high result 0x00000001.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the segmented pipelined adder/subtractor.
// Operation encoding and the per-stage segment width live here.
package pipe_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int seg_width(input int width, input int segments);
    return (segments > 0) ? width / segments : width;
  endfunction

endpackage

// File: rtl/pipe_addsub_segment.sv
// One carry segment: combinational SEG_W-bit add with carry in/out.
// c_msb is the carry into the top bit, used for signed overflow.
module addsub_segment #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [SEG_W:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, ci};
  assign s     = full[SEG_W-1:0];
  assign co    = full[SEG_W];
  assign c_msb = s[SEG_W-1] ^ a[SEG_W-1] ^ b[SEG_W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Segmented pipelined adder/subtractor, one carry segment per stage.
// The whole pipe stalls together when the output beat is not taken.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SEGMENTS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_number_1,
  input  logic [WIDTH-1:0] i_number_2,
  input  logic             i_sub,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int SW    = seg_width(WIDTH, SEGMENTS);
  localparam int L     = SEGMENTS - 1;
  localparam int DEPTH = (SEGMENTS > 1) ? SEGMENTS - 1 : 1;
  localparam logic [WIDTH-1:0] SEG_MASK =
    {WIDTH{1'b1}} >> (WIDTH - SW);

  if (SEGMENTS < 1 || (WIDTH % SEGMENTS) != 0) begin : g_bad_cfg
    $error("pipe_addsub: WIDTH must be a multiple of SEGMENTS >= 1");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  logic             v_q  [SEGMENTS];
  logic             v_in [SEGMENTS];

  logic [WIDTH-1:0] a_q [DEPTH];
  logic [WIDTH-1:0] b_q [DEPTH];
  logic [WIDTH-1:0] r_q [DEPTH];
  logic             c_q [DEPTH];

  logic [WIDTH-1:0] a_in [SEGMENTS];
  logic [WIDTH-1:0] b_in [SEGMENTS];
  logic [WIDTH-1:0] r_in [SEGMENTS];
  logic [WIDTH-1:0] r_nx [SEGMENTS];
  logic             c_in [SEGMENTS];
  logic             c_nx [SEGMENTS];
  logic             m_nx [SEGMENTS];

  assign advance = !o_valid || i_ready;
  assign o_ready = advance;
  assign o_valid = v_q[L];

  // Subtract is A + ~B + 1; the external carry only applies to adds.
  assign b_eff   = (i_sub == OP_SUB) ? ~i_number_2 : i_number_2;
  assign c_first = (i_sub == OP_SUB) ? 1'b1 : i_carry;

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
    logic [SW-1:0] s;

    if (k == 0) begin : g_head
      assign a_in[k] = i_number_1;
      assign b_in[k] = b_eff;
      assign c_in[k] = c_first;
      assign r_in[k] = '0;
      assign v_in[k] = i_valid;
    end else begin : g_body
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign r_in[k] = r_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    addsub_segment #(
      .SEG_W(SW)
    ) u_seg (
      .a    (a_in[k][k*SW +: SW]),
      .b    (b_in[k][k*SW +: SW]),
      .ci   (c_in[k]),
      .s    (s),
      .co   (c_nx[k]),
      .c_msb(m_nx[k])
    );

    assign r_nx[k] = (r_in[k] & ~(SEG_MASK << (k*SW)))
                   | (WIDTH'(s) << (k*SW));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SEGMENTS; k++) v_q[k] <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < SEGMENTS; k++) v_q[k] <= v_in[k];
    end
  end

  // Intermediate data carries no reset; bubbles leave it untouched.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < SEGMENTS - 1; k++) begin
      if (advance && v_in[k]) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        r_q[k] <= r_nx[k];
        c_q[k] <= c_nx[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      result_o   <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
      zero_o     <= 1'b0;
    end else if (advance && v_in[L]) begin
      result_o   <= r_nx[L];
      carry_o    <= c_nx[L];
      overflow_o <= c_nx[L] ^ m_nx[L];
      zero_o     <= (r_nx[L] == '0);
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Randomised bench for pipe_addsub against a plain-arithmetic model.
// Directed cases pin latency and literal results.
module tb_pipe_addsub;

  localparam int W = 32;
  localparam int S = 4;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_number_1 = '0;
  logic [W-1:0] i_number_2 = '0;
  logic         i_sub = 1'b0;
  logic         i_carry = 1'b0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [W-1:0] result_o;
  logic         carry_o;
  logic         overflow_o;
  logic         zero_o;

  pipe_addsub #(.WIDTH(W), .SEGMENTS(S)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_number_1(i_number_1),
    .i_number_2(i_number_2),
    .i_sub     (i_sub),
    .i_carry   (i_carry),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .result_o  (result_o),
    .carry_o   (carry_o),
    .overflow_o(overflow_o),
    .zero_o    (zero_o)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [34:0] q[$];
  int dcyc[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference from integer arithmetic: {result, carry, overflow, zero}.
  function automatic logic [34:0] model(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic sub,
                                        input logic cin);
    longint sa, sb, ex, ua, ub, u;
    logic [W-1:0] r;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ex = sub ? sa - sb : sa + sb + longint'(cin);
    u  = sub ? ua - ub : ua + ub + longint'(cin);
    v  = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
    c  = sub ? (ua >= ub) : (u >= 64'sd4294967296);
    r  = u[31:0];
    return {r, c, v, (r == '0)};
  endfunction

  function automatic logic [34:0] outs();
    return {result_o, carry_o, overflow_o, zero_o};
  endfunction

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst_n) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 64'(o_valid), 64'd0);
        end else begin
          chk("model_result", 64'(outs()), 64'(q[0]));
          if (i_ready) begin
            void'(q.pop_front());
            dcyc.push_back(cyc);
          end
        end
      end
      if (i_valid && o_ready)
        q.push_back(model(i_number_1, i_number_2, i_sub, i_carry));
    end
  end

  task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
    i_number_1 = a;
    i_number_2 = b;
    i_sub      = sub;
    i_carry    = cin;
    i_valid    = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic cin);
    int n;
    set_in(a, b, sub, cin);
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 64'(n), 64'd0);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic sub,
                          input logic cin, input logic [34:0] exp,
                          output logic [34:0] got);
    int n;
    beat(a, b, sub, cin);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_valid && n < 20);
    chk({nm, "_latency"}, 64'(n), 64'(S));
    got = outs();
    chk(nm, 64'(got), 64'(exp));
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edge_v[5];
    edge_v = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] got;
    logic [W-1:0] held;
    int n;

    #12;
    chk("reset_outs", 64'({o_valid, outs()}), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("ready_after_reset", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    #1;

    chk("pin_model_add", 64'(model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0)),
        64'({32'h0, 1'b1, 1'b0, 1'b1}));
    chk("pin_model_sub", 64'(model(32'h5, 32'h7, 1'b1, 1'b0)),
        64'({32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}));

    directed("wrap_add", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
             {32'h0, 1'b1, 1'b0, 1'b1}, got);
    directed("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
             {32'h8000_0000, 1'b0, 1'b1, 1'b0}, got);
    directed("sub_neg", 32'h5, 32'h7, 1'b1, 1'b0,
             {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}, got);
    directed("sub_ignores_cin", 32'h9, 32'h9, 1'b1, 1'b0,
             {32'h0, 1'b1, 1'b0, 1'b1}, got);
    directed("mw_low", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
             {32'h0, 1'b1, 1'b0, 1'b1}, got);
    directed("mw_high", 32'h0, 32'h0, 1'b0, got[2],
             {32'h1, 1'b0, 1'b0, 1'b0}, got);

    // Back-to-back burst must emerge on consecutive cycles.
    dcyc.delete();
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      beat($urandom, $urandom, 1'($urandom), 1'($urandom));
    repeat (10) @(posedge i_clk);
    #1;
    chk("burst_count", 64'(dcyc.size()), 64'd8);
    if (dcyc.size() == 8)
      chk("burst_spacing", 64'(dcyc[7] - dcyc[0]), 64'd7);

    // Fill the pipe with the sink stalled, then hold for three cycles.
    i_ready = 1'b0;
    for (int i = 0; i < S; i++)
      beat(pick(), pick(), 1'($urandom), 1'($urandom));
    set_in(pick(), pick(), 1'b0, 1'b1);
    held = result_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("stall_ready", 64'(o_ready), 64'd0);
      chk("stall_hold", 64'({o_valid, result_o}), 64'({1'b1, held}));
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    chk("stall_drain", 64'(q.size()), 64'd0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++)
      beat($urandom, $urandom, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(o_valid), 64'd0);
    q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("midreset_ready", 64'(o_ready), 64'd1);
    n = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_valid) n++;
    end
    chk("midreset_stale", 64'(n), 64'd0);
    @(posedge i_clk);
    #1;

    // Random traffic with random backpressure and bubbles.
    for (int i = 0; i < 400; i++) begin
      i_ready    = ($urandom_range(0, 3) != 0);
      i_valid    = ($urandom_range(0, 2) != 0);
      i_number_1 = pick();
      i_number_2 = pick();
      i_sub      = 1'($urandom);
      i_carry    = 1'($urandom);
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (12) @(posedge i_clk);
    #1;
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
